// File: rtl/interrupt_ack_sequencer.sv
// Purpose : turns the priority resolver's INT/INT_VEC into the CPU INT line and runs the two-pulse INTA handshake.
// Latency : INT one cycle after INT_REQ; INTA-driven outputs one cycle after the SYNC_STAGES-th edge sampling INTA_N.
// Flow    : no backpressure; the CPU paces the sequence, an abandoned gap is dropped after GAP_TIMEOUT cycles.
//
// Ports:
//   CLK, RESET_N        clock, async active-low reset
//   INTA_N              CPU acknowledge (active low, asynchronous)
//   INT_REQ, INT_VEC    request and winning level from the priority resolver
//   ICW2_T, AEOI_MODE   vector base T7..T3 and automatic-EOI mode
//   INT                 interrupt request to the CPU
//   ACK_FIRST           1-cycle strobe: set ISR / clear IRR for the latched level
//   ACK_SECOND          1-cycle strobe on the second acknowledge
//   EOI_AUTO            1-cycle automatic-EOI strobe
//   SPURIOUS            high while the current sequence is spurious
//   D_OUT, D_OE         vector byte and data-bus output enable

module interrupt_ack_sequencer #(
  parameter int SYNC_STAGES = 2,
  parameter int GAP_TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       INTA_N,
  input  logic       INT_REQ,
  input  logic [2:0] INT_VEC,
  input  logic [4:0] ICW2_T,
  input  logic       AEOI_MODE,
  output logic       INT,
  output logic       ACK_FIRST,
  output logic       ACK_SECOND,
  output logic       EOI_AUTO,
  output logic       SPURIOUS,
  output logic [7:0] D_OUT,
  output logic       D_OE
);

  // Counter wide enough to hold GAP_TIMEOUT itself; a disabled timeout
  // still needs a legal 1-bit vector.
  localparam int CNT_W = (GAP_TIMEOUT > 0) ? $clog2(GAP_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LIMIT = CNT_W'(GAP_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_P1,
    ST_GAP,
    ST_P2
  } state_t;

  // ---------------------------------------------------------------
  // INTA_N synchronizer and edge detect
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] inta_sync_q;
  logic                   inta_prev_q;
  logic                   inta_s;
  logic                   inta_fall;
  logic                   inta_rise;

  // Flops reset to 1 so a released reset never looks like an INTA fall.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      inta_sync_q <= '1;
      inta_prev_q <= 1'b1;
    end else begin
      inta_sync_q <= {inta_sync_q[SYNC_STAGES-2:0], INTA_N};
      inta_prev_q <= inta_sync_q[SYNC_STAGES-1];
    end
  end

  // Edges are decoded combinationally from the last sync stage so the FSM
  // acts on the edge that brings the new level out of the chain (edge k+N).
  assign inta_s    = inta_sync_q[SYNC_STAGES-1];
  assign inta_fall =  inta_prev_q & ~inta_s;
  assign inta_rise = ~inta_prev_q &  inta_s;

  // ---------------------------------------------------------------
  // Gap counter next-state
  // ---------------------------------------------------------------
  logic [CNT_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] gap_cnt_d;
  logic             gap_expired;

  always_comb begin
    gap_cnt_d   = gap_cnt_q + CNT_W'(1);
    // gap_cnt_d counts cycles spent in GAP, so equality lands exactly
    // GAP_TIMEOUT edges after the entry edge.
    gap_expired = (GAP_TIMEOUT != 0) && (gap_cnt_d == GAP_LIMIT);
  end

  // ---------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // ---------------------------------------------------------------
  state_t     state_q;
  logic [7:0] vec_q;
  logic       int_q;
  logic       ack_first_q;
  logic       ack_second_q;
  logic       eoi_auto_q;
  logic       spurious_q;
  logic [7:0] d_out_q;
  logic       d_oe_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      vec_q        <= 8'h00;
      gap_cnt_q    <= '0;
      int_q        <= 1'b0;
      ack_first_q  <= 1'b0;
      ack_second_q <= 1'b0;
      eoi_auto_q   <= 1'b0;
      spurious_q   <= 1'b0;
      d_out_q      <= 8'h00;
      d_oe_q       <= 1'b0;
    end else begin
      // Strobes are one cycle wide unless re-asserted below.
      ack_first_q  <= 1'b0;
      ack_second_q <= 1'b0;
      eoi_auto_q   <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (inta_fall) begin
            // Acknowledge without a request: run the handshake as spurious
            // so the CPU still gets the default vector (level 7).
            state_q    <= ST_P1;
            vec_q      <= {ICW2_T, 3'b111};
            spurious_q <= 1'b1;
          end else if (INT_REQ) begin
            state_q <= ST_REQ;
            int_q   <= 1'b1;
          end
        end

        ST_REQ: begin
          // INT stays up even if INT_REQ drops; the INTA cycle that the CPU
          // has already committed to resolves the request as spurious.
          if (inta_fall) begin
            state_q <= ST_P1;
            int_q   <= 1'b0;
            if (INT_REQ) begin
              vec_q       <= {ICW2_T, INT_VEC};
              ack_first_q <= 1'b1;
            end else begin
              vec_q      <= {ICW2_T, 3'b111};
              spurious_q <= 1'b1;
            end
          end
        end

        ST_P1: begin
          // Bus floats during the first pulse.
          d_oe_q <= 1'b0;
          if (inta_rise) begin
            state_q   <= ST_GAP;
            gap_cnt_q <= '0;
          end
        end

        ST_GAP: begin
          gap_cnt_q <= gap_cnt_d;
          if (inta_fall) begin
            state_q      <= ST_P2;
            d_oe_q       <= 1'b1;
            d_out_q      <= vec_q;
            ack_second_q <= 1'b1;
          end else if (gap_expired) begin
            // Abandoned sequence: ISR stays set in the resolver and waits
            // for a software EOI, so no further strobes here.
            state_q    <= ST_IDLE;
            spurious_q <= 1'b0;
          end
        end

        ST_P2: begin
          if (inta_rise) begin
            state_q    <= ST_IDLE;
            d_oe_q     <= 1'b0;
            spurious_q <= 1'b0;
            // AEOI_MODE is only looked at here, at the end of the sequence.
            eoi_auto_q <= AEOI_MODE & ~spurious_q;
          end
        end

        default: begin
          state_q    <= ST_IDLE;
          int_q      <= 1'b0;
          d_oe_q     <= 1'b0;
          spurious_q <= 1'b0;
        end
      endcase
    end
  end

  assign INT        = int_q;
  assign ACK_FIRST  = ack_first_q;
  assign ACK_SECOND = ack_second_q;
  assign EOI_AUTO   = eoi_auto_q;
  assign SPURIOUS   = spurious_q;
  assign D_OUT      = d_out_q;
  assign D_OE       = d_oe_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Purpose : directed self-checking bench for interrupt_ack_sequencer (SYNC_STAGES=2, GAP_TIMEOUT=10).
// Latency : inputs change 1ns after a rising edge; outputs are read 1ns after a rising edge.
// Flow    : fixed cycle counts only, so every run ends on its own.

module tb_interrupt_ack_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       inta_n;
  logic       int_req;
  logic [2:0] int_vec;
  logic [4:0] icw2_t;
  logic       aeoi_mode;
  logic       int_o;
  logic       ack_first;
  logic       ack_second;
  logic       eoi_auto;
  logic       spurious;
  logic [7:0] d_out;
  logic       d_oe;

  int n_tests = 0;
  int n_fail  = 0;

  // Strobe counters, written only by the monitor below.
  int n_ack1    = 0;
  int n_ack2    = 0;
  int n_eoi     = 0;
  int n_overlap = 0;

  int b_ack1, b_ack2, b_eoi;

  interrupt_ack_sequencer #(
    .SYNC_STAGES(2),
    .GAP_TIMEOUT(10)
  ) dut (
    .CLK       (clk),
    .RESET_N   (rst_n),
    .INTA_N    (inta_n),
    .INT_REQ   (int_req),
    .INT_VEC   (int_vec),
    .ICW2_T    (icw2_t),
    .AEOI_MODE (aeoi_mode),
    .INT       (int_o),
    .ACK_FIRST (ack_first),
    .ACK_SECOND(ack_second),
    .EOI_AUTO  (eoi_auto),
    .SPURIOUS  (spurious),
    .D_OUT     (d_out),
    .D_OE      (d_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_ack1 = n_ack1 + int'(ack_first);
      n_ack2 = n_ack2 + int'(ack_second);
      n_eoi  = n_eoi  + int'(eoi_auto);
      if (int'(ack_first) + int'(ack_second) + int'(eoi_auto) > 1)
        n_overlap = n_overlap + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive INTA_N and wait until the FSM has reacted (sample edge + 2 sync edges).
  task automatic inta_edge(input logic v);
    inta_n = v;
    repeat (3) tick();
  endtask

  task automatic snap();
    b_ack1 = n_ack1;
    b_ack2 = n_ack2;
    b_eoi  = n_eoi;
  endtask

  initial begin
    rst_n     = 1'b0;
    inta_n    = 1'b1;
    int_req   = 1'b0;
    int_vec   = 3'd0;
    icw2_t    = 5'b01000;
    aeoi_mode = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    check_eq("rst_int",   int_o,    8'd0);
    check_eq("rst_doe",   d_oe,     8'd0);
    check_eq("rst_dout",  d_out,    8'h00);
    check_eq("rst_spur",  spurious, 8'd0);
    check_eq("rst_strb",  {ack_first, ack_second, eoi_auto}, 8'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    // ---------------- normal acknowledge ----------------
    int_vec = 3'd3;
    int_req = 1'b1;
    check_eq("n_int_pre", int_o, 8'd0);
    tick();
    check_eq("n_int_rise", int_o, 8'd1);
    snap();
    inta_n = 1'b0;
    repeat (2) tick();
    check_eq("n_int_latency", int_o, 8'd1);
    check_eq("n_ack1_latency", ack_first, 8'd0);
    tick();
    check_eq("n_int_fall", int_o, 8'd0);
    check_eq("n_ack1", ack_first, 8'd1);
    check_eq("n_doe_p1", d_oe, 8'd0);
    check_eq("n_spur", spurious, 8'd0);
    int_req = 1'b0;
    tick();
    check_eq("n_ack1_width", ack_first, 8'd0);
    inta_edge(1'b1);
    inta_edge(1'b0);
    check_eq("n_doe_p2", d_oe, 8'd1);
    check_eq("n_dout", d_out, 8'h43);
    check_eq("n_ack2", ack_second, 8'd1);
    inta_edge(1'b1);
    check_eq("n_doe_end", d_oe, 8'd0);
    check_eq("n_eoi_none", eoi_auto, 8'd0);
    repeat (3) tick();
    check_eq("n_cnt_ack1", 8'(n_ack1 - b_ack1), 8'd1);
    check_eq("n_cnt_ack2", 8'(n_ack2 - b_ack2), 8'd1);
    check_eq("n_cnt_eoi",  8'(n_eoi  - b_eoi),  8'd0);

    // ---------------- automatic EOI ----------------
    aeoi_mode = 1'b1;
    int_vec   = 3'd3;
    int_req   = 1'b1;
    tick();
    snap();
    inta_edge(1'b0);
    int_req = 1'b0;
    inta_edge(1'b1);
    inta_edge(1'b0);
    check_eq("a_dout", d_out, 8'h43);
    inta_n = 1'b1;
    repeat (2) tick();
    check_eq("a_eoi_early", eoi_auto, 8'd0);
    tick();
    check_eq("a_eoi", eoi_auto, 8'd1);
    check_eq("a_doe_end", d_oe, 8'd0);
    tick();
    check_eq("a_eoi_width", eoi_auto, 8'd0);
    repeat (2) tick();
    check_eq("a_cnt_eoi", 8'(n_eoi - b_eoi), 8'd1);

    // ---------------- spurious request (AEOI still on) ----------------
    snap();
    int_vec = 3'd2;
    int_req = 1'b1;
    tick();
    check_eq("s_int_rise", int_o, 8'd1);
    int_req = 1'b0;
    tick();
    check_eq("s_int_held", int_o, 8'd1);
    inta_edge(1'b0);
    check_eq("s_spur", spurious, 8'd1);
    check_eq("s_int_fall", int_o, 8'd0);
    check_eq("s_no_ack1", ack_first, 8'd0);
    inta_edge(1'b1);
    inta_edge(1'b0);
    check_eq("s_dout", d_out, 8'h47);
    check_eq("s_doe", d_oe, 8'd1);
    inta_edge(1'b1);
    check_eq("s_spur_clr", spurious, 8'd0);
    check_eq("s_doe_end", d_oe, 8'd0);
    repeat (3) tick();
    check_eq("s_cnt_ack1", 8'(n_ack1 - b_ack1), 8'd0);
    check_eq("s_cnt_eoi",  8'(n_eoi  - b_eoi),  8'd0);
    aeoi_mode = 1'b0;

    // ---------------- gap timeout ----------------
    snap();
    int_vec = 3'd5;
    int_req = 1'b1;
    tick();
    inta_edge(1'b0);
    check_eq("t_ack1", ack_first, 8'd1);
    inta_edge(1'b1);
    repeat (10) tick();
    check_eq("t_int_idle", int_o, 8'd0);
    tick();
    check_eq("t_int_reassert", int_o, 8'd1);
    check_eq("t_doe", d_oe, 8'd0);
    check_eq("t_cnt_ack2", 8'(n_ack2 - b_ack2), 8'd0);
    check_eq("t_cnt_eoi",  8'(n_eoi  - b_eoi),  8'd0);

    // ---------------- mid-sequence stability and reset ----------------
    snap();
    int_vec = 3'd3;
    inta_edge(1'b0);
    check_eq("m_ack1", ack_first, 8'd1);
    int_req = 1'b0;
    inta_edge(1'b1);
    int_vec = 3'd6;
    tick();
    inta_edge(1'b0);
    check_eq("m_dout", d_out, 8'h43);
    check_eq("m_doe", d_oe, 8'd1);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("m_rst_doe",  d_oe,  8'd0);
    check_eq("m_rst_dout", d_out, 8'h00);
    check_eq("m_rst_outs", {int_o, ack_first, ack_second, eoi_auto, spurious}, 8'd0);
    inta_n = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_eq("m_post_int", int_o, 8'd0);
    check_eq("m_post_doe", d_oe, 8'd0);
    check_eq("m_cnt_ack2", 8'(n_ack2 - b_ack2), 8'd1);
    check_eq("m_cnt_eoi",  8'(n_eoi  - b_eoi),  8'd0);
    int_vec = 3'd1;
    int_req = 1'b1;
    tick();
    check_eq("m_idle_req", int_o, 8'd1);

    // ---------------- back-to-back requests ----------------
    snap();
    inta_edge(1'b0);
    int_vec = 3'd2;
    inta_edge(1'b1);
    inta_edge(1'b0);
    check_eq("b_dout1", d_out, 8'h41);
    inta_edge(1'b1);
    check_eq("b_doe_end1", d_oe, 8'd0);
    tick();
    check_eq("b_int_again", int_o, 8'd1);
    inta_edge(1'b0);
    int_req = 1'b0;
    inta_edge(1'b1);
    inta_edge(1'b0);
    check_eq("b_dout2", d_out, 8'h42);
    inta_edge(1'b1);
    repeat (3) tick();
    check_eq("b_cnt_ack1", 8'(n_ack1 - b_ack1), 8'd2);
    check_eq("b_cnt_ack2", 8'(n_ack2 - b_ack2), 8'd2);
    check_eq("b_int_final", int_o, 8'd0);

    check_eq("strobe_overlap", 8'(n_overlap), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
